rf_operand_fetch: RTL

Initiator side of the 16x16 register-file port set. Accepts decoded source-register requests and drives RAddr1/RAddr2 into the register file. Captures the registered RData1/RData2 and returns an operand pair through a valid/ready handshake. Also owns the write port: turns writeback requests into registered WAddr/WData/Wen, and bypasses in-flight writes so the returned operands are never stale.

---
 rtl/rf_operand_fetch_pkg.sv | 17 +
 rtl/rf_operand_fetch_if.sv | 40 ++++
 rtl/rf_bypass_track.sv | 50 +++++
 rtl/rf_operand_fetch.sv | 126 ++++++++++++
 4 files changed

// File: rtl/rf_operand_fetch_pkg.sv
// Shared constants and FSM state type for the register-file operand fetch block.
package rf_pkg;

   localparam int unsigned DATA_W   = 16;
   localparam int unsigned NUM_REGS = 16;
   localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

   localparam logic [ADDR_W-1:0] ZERO_REG = '0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      VALID = 2'd3
   } state_t;

endpackage

// File: rtl/rf_operand_fetch_if.sv
// Request, writeback, register-file and operand-return signals of the operand fetch port set.
interface rf_operand_fetch_if;
   import rf_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_rs1;
   logic [ADDR_W-1:0] req_rs2;

   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;

   logic [ADDR_W-1:0] RAddr1;
   logic [ADDR_W-1:0] RAddr2;
   logic [ADDR_W-1:0] WAddr;
   logic [DATA_W-1:0] WData;
   logic              Wen;
   logic [DATA_W-1:0] RData1;
   logic [DATA_W-1:0] RData2;

   logic              op_valid;
   logic              op_ready;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;

   // master: the operand fetch block; slave: pipeline and register file around it
   modport master (
      input  req_valid, req_rs1, req_rs2, wb_valid, wb_addr, wb_data,
             RData1, RData2, op_ready,
      output req_ready, RAddr1, RAddr2, WAddr, WData, Wen, op_valid, op_a, op_b
   );

   modport slave (
      output req_valid, req_rs1, req_rs2, wb_valid, wb_addr, wb_data,
             RData1, RData2, op_ready,
      input  req_ready, RAddr1, RAddr2, WAddr, WData, Wen, op_valid, op_a, op_b
   );

endinterface

// File: rtl/rf_bypass_track.sv
// Per-operand writeback bypass: match logic, override flag and shadow value
// covering writes the register file read cannot yet reflect.
module rf_bypass_track
   import rf_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              track,
   input  logic              clear,
   input  logic [ADDR_W-1:0] rs,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [DATA_W-1:0] rdata,
   output logic              hit_c,
   output logic [DATA_W-1:0] fetched_c
);

   logic              override_q;
   logic [DATA_W-1:0] shadow_q;

   assign hit_c = track && wb_valid && (wb_addr == rs) && (rs != ZERO_REG);

   // Same-edge write beats the shadow, which beats the file's read data
   always_comb begin
      fetched_c = rdata;
      if (rs == ZERO_REG) begin
         fetched_c = '0;
      end else if (hit_c) begin
         fetched_c = wb_data;
      end else if (override_q) begin
         fetched_c = shadow_q;
      end
   end

   // A new accept restarts tracking, but a write on the accepting edge still counts
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         override_q <= 1'b0;
         shadow_q   <= '0;
      end else if (clear) begin
         override_q <= hit_c;
         shadow_q   <= hit_c ? wb_data : '0;
      end else if (hit_c) begin
         override_q <= 1'b1;
         shadow_q   <= wb_data;
      end
   end

endmodule

// File: rtl/rf_operand_fetch.sv
// Register-file operand fetch initiator: issues reads, bypasses in-flight writebacks,
// returns operand pairs via valid/ready. Optional bypass counter under RF_BYPASS_CNT_EN.
module rf_operand_fetch
   import rf_pkg::*;
(
   input  logic               Clock,
   input  logic               Reset,
   rf_operand_fetch_if.master bus
`ifdef RF_BYPASS_CNT_EN
   ,
   output logic [15:0]        bypass_cnt
`endif
);

   state_t            state_q;
   state_t            state_d;
   logic              accept_c;
   logic              track_c;
   logic              hit1_c;
   logic              hit2_c;
   logic [ADDR_W-1:0] rs1_sel_c;
   logic [ADDR_W-1:0] rs2_sel_c;
   logic [DATA_W-1:0] fetch1_c;
   logic [DATA_W-1:0] fetch2_c;

   // Next state and request acceptance
   always_comb begin
      state_d       = state_q;
      bus.req_ready = 1'b0;
      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_d = ISSUE;
         end
         ISSUE: state_d = WAIT;
         WAIT:  state_d = VALID;
         VALID: begin
            if (bus.op_ready) begin
               bus.req_ready = 1'b1;
               state_d       = bus.req_valid ? ISSUE : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   assign accept_c  = bus.req_valid && bus.req_ready;
   // Bypass window: accepting edge through VALID, closed once the pair is consumed
   assign track_c   = accept_c || (state_q == ISSUE) || (state_q == WAIT) ||
                      ((state_q == VALID) && !bus.op_ready);
   assign rs1_sel_c = accept_c ? bus.req_rs1 : bus.RAddr1;
   assign rs2_sel_c = accept_c ? bus.req_rs2 : bus.RAddr2;

   rf_bypass_track u_track_a (
      .clk       (Clock),
      .rst_n     (Reset),
      .track     (track_c),
      .clear     (accept_c),
      .rs        (rs1_sel_c),
      .wb_valid  (bus.wb_valid),
      .wb_addr   (bus.wb_addr),
      .wb_data   (bus.wb_data),
      .rdata     (bus.RData1),
      .hit_c     (hit1_c),
      .fetched_c (fetch1_c)
   );

   rf_bypass_track u_track_b (
      .clk       (Clock),
      .rst_n     (Reset),
      .track     (track_c),
      .clear     (accept_c),
      .rs        (rs2_sel_c),
      .wb_valid  (bus.wb_valid),
      .wb_addr   (bus.wb_addr),
      .wb_data   (bus.wb_data),
      .rdata     (bus.RData2),
      .hit_c     (hit2_c),
      .fetched_c (fetch2_c)
   );

   // Write port staging, read address latch and operand return registers
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         bus.Wen      <= 1'b0;
         bus.WAddr    <= '0;
         bus.WData    <= '0;
         bus.RAddr1   <= '0;
         bus.RAddr2   <= '0;
         bus.op_valid <= 1'b0;
         bus.op_a     <= '0;
         bus.op_b     <= '0;
      end else begin
         bus.Wen   <= bus.wb_valid;
         bus.WAddr <= bus.wb_addr;
         bus.WData <= bus.wb_data;
         if (accept_c) begin
            bus.RAddr1 <= bus.req_rs1;
            bus.RAddr2 <= bus.req_rs2;
         end
         if (state_q == WAIT) begin
            bus.op_valid <= 1'b1;
            bus.op_a     <= fetch1_c;
            bus.op_b     <= fetch2_c;
         end else if (state_q == VALID) begin
            if (bus.op_ready) bus.op_valid <= 1'b0;
            if (hit1_c && !bus.op_ready) bus.op_a <= bus.wb_data;
            if (hit2_c && !bus.op_ready) bus.op_b <= bus.wb_data;
         end
      end
   end

`ifdef RF_BYPASS_CNT_EN
   // Edges with at least one operand override; wraps naturally
   always_ff @(posedge Clock) begin
      if (!Reset)                bypass_cnt <= '0;
      else if (hit1_c || hit2_c) bypass_cnt <= bypass_cnt + 16'd1;
   end
`endif

endmodule
